// File: rtl/rate_block_packer.sv
// rate_block_packer: pads a 64-bit word message with Keccak pad10*1 and packs it into 576-bit rate blocks.
//   clk       rising-edge clock
//   reset     synchronous active-high reset; drops all block and message progress
//   in        message word, byte 0 in the MSBs
//   in_ready  host offers a word
//   is_last   offered word is the final message word
//   byte_num  valid bytes in the final word (0..7)
//   ack       combinational; offered word is taken at this rising edge
//   out       block being built or completed, word i at out[575-64i -: 64]
//   out_ready registered; out holds a complete block
//   f_ack     permutation core has taken the block
module rate_block_packer #(
    parameter int WORD_W     = 64,
    parameter int RATE_WORDS = 9
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WORD_W-1:0]            in,
    input  logic                         in_ready,
    input  logic                         is_last,
    input  logic [2:0]                   byte_num,
    output logic                         ack,
    output logic [RATE_WORDS*WORD_W-1:0] out,
    output logic                         out_ready,
    input  logic                         f_ack
);
    typedef enum logic [1:0] {ABSORB, PAD, FULL, DONE} state_t;
    state_t              state;
    logic [3:0]          count;
    logic                msg_end;
    logic [9:0]          base;
    logic                last_slot;
    logic [WORD_W-1:0]   keep;
    logic [WORD_W-1:0]   marker;
    logic [WORD_W-1:0]   absorb_word;
    logic [WORD_W-1:0]   pad_word;
    assign ack         = in_ready & (state == ABSORB) & ~reset;
    // word 0 sits in the MSBs, so slot n starts (RATE_WORDS-1-n) words up from bit 0
    assign base        = 10'((RATE_WORDS - 1 - int'(count)) * WORD_W);
    assign last_slot   = count == 4'(RATE_WORDS - 1);
    // keep bytes 0..k-1 of the final word and drop the 0x01 pad byte into byte k
    assign keep        = ~({WORD_W{1'b1}} >> {byte_num, 3'b000});
    assign marker      = 64'h0100_0000_0000_0000 >> {byte_num, 3'b000};
    // the closing 0x80 lands in the LSB byte of slot 8, merging with 0x01 when k=7
    assign absorb_word = (is_last ? (in & keep) | marker : in) |
                         (is_last & last_slot ? 64'h80 : 64'h0);
    assign pad_word    = last_slot ? 64'h80 : 64'h0;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ABSORB;
            out       <= '0;
            out_ready <= 1'b0;
            count     <= '0;
            msg_end   <= 1'b0;
        end else begin
            case (state)
                ABSORB: if (in_ready) begin
                    out[base +: WORD_W] <= absorb_word;
                    count               <= count + 4'd1;
                    msg_end             <= is_last;
                    if (last_slot) begin
                        out_ready <= 1'b1;
                        state     <= FULL;
                    end else if (is_last) begin
                        state <= PAD;
                    end
                end
                PAD: begin
                    out[base +: WORD_W] <= pad_word;
                    count               <= count + 4'd1;
                    if (last_slot) begin
                        out_ready <= 1'b1;
                        state     <= FULL;
                    end
                end
                FULL: if (f_ack) begin
                    out       <= '0;
                    out_ready <= 1'b0;
                    count     <= '0;
                    state     <= msg_end ? DONE : ABSORB;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rate_block_packer.sv
// tb_rate_block_packer: directed checks of padding, packing, handshake and reset of rate_block_packer.
module tb_rate_block_packer;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [63:0]  in = '0;
    logic         in_ready = 1'b0;
    logic         is_last = 1'b0;
    logic [2:0]   byte_num = '0;
    logic         ack;
    logic [575:0] out;
    logic         out_ready;
    logic         f_ack = 1'b0;
    int           n_checks = 0;
    int           n_fail = 0;
    logic [575:0] exp_blk;
    localparam logic [575:0] EMPTY_BLK = {8'h01, 560'h0, 8'h80};

    rate_block_packer dut (
        .clk(clk), .reset(reset), .in(in), .in_ready(in_ready), .is_last(is_last),
        .byte_num(byte_num), .ack(ack), .out(out), .out_ready(out_ready), .f_ack(f_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [575:0] got, input logic [575:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] nib(input int i);
        return {16{4'(i)}};
    endfunction

    // offer one word, confirm it is taken, then withdraw the offer
    task automatic send(input logic [63:0] w, input logic last, input logic [2:0] k, input string tag);
        in = w; is_last = last; byte_num = k; in_ready = 1'b1;
        #1 check(tag, 576'(ack), 576'(1));
        @(negedge clk);
        in_ready = 1'b0; is_last = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; f_ack = 1'b0; in_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // reset held with the host offering words
        in_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("rst_ack", 576'(ack), 576'(0));
            check("rst_out", out, '0);
            check("rst_rdy", 576'(out_ready), 576'(0));
        end
        // empty message: pad-only block, then DONE
        reset = 1'b0;
        send(64'h0, 1'b1, 3'd0, "empty_ack");
        in_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1 check("empty_pad_ack", 576'(ack), 576'(0));
            check("empty_pad_rdy", 576'(out_ready), 576'(0));
            @(negedge clk);
        end
        #1 check("empty_rdy", 576'(out_ready), 576'(1));
        check("empty_out", out, EMPTY_BLK);
        check("empty_full_ack", 576'(ack), 576'(0));
        f_ack = 1'b1;
        @(negedge clk);
        f_ack = 1'b0;
        #1 check("empty_rel_out", out, '0);
        check("empty_rel_rdy", 576'(out_ready), 576'(0));
        check("empty_done_ack", 576'(ack), 576'(0));
        @(negedge clk);
        #1 check("empty_done_ack2", 576'(ack), 576'(0));
        in_ready = 1'b0;

        // nine full words back-to-back, then a final word with k=7 landing in slot 8
        do_reset();
        exp_blk = '0;
        in_ready = 1'b1; is_last = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            in = nib(i);
            exp_blk = {exp_blk[511:0], nib(i)};
            #1 check("nine_ack", 576'(ack), 576'(1));
            @(negedge clk);
        end
        #1 check("nine_rdy", 576'(out_ready), 576'(1));
        check("nine_out", out, exp_blk);
        check("nine_full_ack", 576'(ack), 576'(0));
        f_ack = 1'b1; in_ready = 1'b0;
        @(negedge clk);
        f_ack = 1'b0;
        #1 check("nine_rel_out", out, '0);
        check("nine_rel_rdy", 576'(out_ready), 576'(0));
        exp_blk = '0;
        for (int i = 1; i <= 8; i++) begin
            send(nib(9 - i), 1'b0, 3'd0, "k7_word_ack");
            exp_blk = {exp_blk[511:0], nib(9 - i)};
        end
        exp_blk = {exp_blk[511:0], 64'hAABBCCDDEEFF0781};
        send(64'hAABBCCDDEEFF0700, 1'b1, 3'd7, "k7_last_ack");
        #1 check("k7_rdy", 576'(out_ready), 576'(1));
        check("k7_out", out, exp_blk);
        f_ack = 1'b1;
        @(negedge clk);
        f_ack = 1'b0; in_ready = 1'b1;
        #1 check("k7_done_ack", 576'(ack), 576'(0));
        check("k7_done_rdy", 576'(out_ready), 576'(0));
        @(negedge clk);
        #1 check("k7_done_ack2", 576'(ack), 576'(0));

        // final word k=3 in slot 2, padding fills slots 3..8
        do_reset();
        send(64'h0123456789ABCDEF, 1'b0, 3'd0, "k3_w0_ack");
        send(64'hFEDCBA9876543210, 1'b0, 3'd0, "k3_w1_ack");
        send(64'hDEADBEEF12345678, 1'b1, 3'd3, "k3_last_ack");
        for (int i = 1; i < 7; i++) begin
            #1 check("k3_wait_rdy", 576'(out_ready), 576'(0));
            @(negedge clk);
        end
        #1 check("k3_rdy", 576'(out_ready), 576'(1));
        check("k3_out", out, {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'hDEADBE0100000000,
                              320'h0, 64'h80});

        // reset in the middle of padding, then a fresh one-word message
        do_reset();
        send(64'h0, 1'b1, 3'd0, "padrst_ack");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1 check("padrst_out", out, '0);
        check("padrst_rdy", 576'(out_ready), 576'(0));
        send(64'h0123456789ABCDEF, 1'b1, 3'd7, "fresh_ack");
        repeat (8) @(negedge clk);
        #1 check("fresh_rdy", 576'(out_ready), 576'(1));
        check("fresh_out", out, {64'h0123456789ABCD01, 448'h0, 64'h80});

        // reset while FULL with f_ack asserted in the same cycle
        do_reset();
        in_ready = 1'b1; is_last = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            in = nib(i);
            @(negedge clk);
        end
        in_ready = 1'b0;
        #1 check("fullrst_pre_rdy", 576'(out_ready), 576'(1));
        reset = 1'b1; f_ack = 1'b1;
        @(negedge clk);
        reset = 1'b0; f_ack = 1'b0;
        #1 check("fullrst_out", out, '0);
        check("fullrst_rdy", 576'(out_ready), 576'(0));
        send(64'h0, 1'b1, 3'd0, "fullrst_fresh_ack");
        repeat (8) @(negedge clk);
        #1 check("fullrst_fresh_rdy", 576'(out_ready), 576'(1));
        check("fullrst_fresh_out", out, EMPTY_BLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rate_block_packer.md
Name: rate_block_packer

Overview:
- Producer side of the f_permutation absorb interface.
- Accepts a message as a stream of 64-bit words, applies Keccak pad10*1 padding (0x01 … 0x80), and packs the result into 576-bit rate blocks.
- Presents each block on out/out_ready and holds it until the permutation core acknowledges it with f_ack.
- Sits between the host word interface and f_permutation's in/in_ready/ack ports.

Parameters:
- WORD_W, 64, width of one message word in bits. Fixed at 64; byte_num encoding depends on it.
- RATE_WORDS, 9, words per rate block. Output block width is RATE_WORDS*WORD_W = 576.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  64  message word; byte 0 is in[63:56].
- in_ready  input  1  host offers a word this cycle.
- is_last  input  1  the offered word is the final message word.
- byte_num  input  3  valid bytes in the final word, 0..7. Ignored unless is_last=1.
- ack  output  1  combinational; the word is consumed at this rising edge.
- out  output  576  block under construction or completed; word i occupies out[575-64i -: 64].
- out_ready  output  1  registered; out holds a complete block.
- f_ack  input  1  permutation core took the block (connects to f_permutation ack).

Behaviour:
- Reset (synchronous, active-high):
  - out=0, out_ready=0, word count=0, state=ABSORB.
  - ack=0 while reset is high.
  - Reset asserted mid-block or mid-padding discards all progress.
- States:
  - ABSORB → PAD on an accepted last word with count<8 after the append.
  - ABSORB → FULL when count reaches 9.
  - PAD → FULL when count reaches 9.
  - FULL → ABSORB on f_ack if the message is not finished.
  - FULL → DONE on f_ack if the message is finished.
  - DONE is left only by reset.
- ack = in_ready & (state==ABSORB) & ~reset. It is low in PAD, FULL and DONE regardless of in_ready.
- Non-last word accepted: the 64 bits are written into slot count, then count increments.
- Last word accepted with byte_num=k:
  - Bytes 0..k-1 come from in.
  - Byte k = 0x01.
  - Bytes k+1..7 = 0.
  - The packer records that the message has ended.
- Full-length final word: the host sends it as non-last, followed by is_last=1 with byte_num=0.
- PAD state: writes one all-zero word per cycle into the next slot; ack stays low.
- Final 0x80 byte: once the message has ended, out[7:0] is ORed with 0x80 in the cycle count reaches 9.
  - If the last data word lands in slot 8 with k=7, the final byte is 0x81.
  - Padding always fits within the current block; no extra block is ever generated.
- count reaches 9 at a rising edge → out_ready=1 from that edge. out is stable while out_ready=1.
- f_ack handling:
  - Sampled only when out_ready=1; ignored otherwise.
  - On a rising edge with out_ready=1 and f_ack=1: next cycle out_ready=0, out=0, count=0, then state → ABSORB or DONE.
- No new word is accepted in the same cycle f_ack releases the block. The first acceptance is possible one cycle later.
- Latency from the last accepted word (slot s) to out_ready: 1 cycle if s=8, otherwise 9-s cycles.

Test Plan:
- Reset held 5 cycles with in_ready=1 → ack=0, out=0, out_ready=0 throughout.
- Empty message (is_last=1, byte_num=0, accepted at cycle 0):
  - ack=1 in cycle 0, ack=0 in cycles 1–8.
  - out_ready=1 after 9 edges, with out = {8'h01, 560'h0, 8'h80}.
  - Further in_ready → ack=0.
- Nine non-last words 64'h1111…11 through 64'h9999…99 presented back-to-back:
  - ack=1 for 9 cycles.
  - out = exact concatenation, word 1 in MSBs; out_ready=1.
  - in_ready held high afterwards → ack=0.
  - f_ack pulse → next cycle out_ready=0, out=0; ack=1 the following cycle.
- Message of 8 full words plus last word 64'hAABBCCDDEEFF0700 with byte_num=7:
  - Slot 8 = 64'hAABBCCDDEEFF0781.
  - out_ready one cycle after acceptance; f_ack → DONE, with ack=0 thereafter.
- Last word with byte_num=3, data 64'hDEADBEEF_xxxxxxxx, in slot 2 → slot 2 = 64'hDEADBE01_00000000, slots 3–7 = 0, slot 8 = 64'h80, out_ready 7 cycles after acceptance.
- Reset asserted during PAD, and separately during FULL with f_ack=1 in the same cycle → next cycle out=0, out_ready=0; a fresh message then packs correctly.
